// File: rtl/multi_consumer_pkg.sv
// Shared constants and the shadow-pipeline entry type for the multi_consumer
// delay-line datapath and the scheduler that feeds it.
package multi_consumer_pkg;

    localparam int DATA_W    = 16;
    localparam int ID_W      = 2;
    localparam int MAX_DEPTH = 7;
    localparam int NUM_TAPS  = 4;

    // Datapath tap depths, bit order of tap_valid / tap_id.
    localparam int TAP_DEPTHS [NUM_TAPS] = '{1, 2, 4, 7};

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } shadow_entry_t;

endpackage

// File: rtl/multi_consumer_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from the pointer upward, with
// the pointer moving just past the winner only when a grant is issued.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
            if (en && !grant_any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                grant_any  = 1'b1;
            end
        end
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/multi_consumer_sched.sv
// Round-robin front end for the multi_consumer datapath: registers one granted
// word per cycle onto d_in and tracks owner/valid of every tapped word.
module multi_consumer_sched #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = multi_consumer_pkg::DATA_W,
    parameter int ID_W      = multi_consumer_pkg::ID_W,
    parameter int MAX_DEPTH = multi_consumer_pkg::MAX_DEPTH
) (
    input  logic                      clock,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      hold,
    output logic [DATA_W-1:0]         d_in,
    output logic                      d_in_valid,
    output logic [3:0]                tap_valid,
    output logic [4*ID_W-1:0]         tap_id,
    output logic                      busy,
    output logic                      drained
);
    import multi_consumer_pkg::*;

    // Handshake: requester i transfers when req_valid[i] && req_ready[i] at a
    // rising edge; req_ready looks at req_valid, so valid must not wait on ready.
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    logic               arb_en;

    assign arb_en    = !hold && !rst;
    assign req_ready = grant;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_arb (
        .clock     (clock),
        .rst       (rst),
        .en        (arb_en),
        .req       (req_valid),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    logic [DATA_W-1:0] d_in_q, d_in_d;
    logic              d_in_valid_q, d_in_valid_d;
    logic [ID_W-1:0]   issue_id_q, issue_id_d;
    shadow_entry_t     shadow_q [MAX_DEPTH];
    shadow_entry_t     shadow_d [MAX_DEPTH];
    logic              busy_prev_q, busy_prev_d;

    always_comb begin
        d_in_d       = '0;
        d_in_valid_d = grant_any;
        issue_id_d   = grant_any ? grant_idx : '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) d_in_d = req_data[i*DATA_W +: DATA_W];
        end
        // The datapath never stalls, so the shadow line shifts every cycle.
        shadow_d[0] = '{valid: d_in_valid_q, id: issue_id_q};
        for (int i = 1; i < MAX_DEPTH; i++) begin
            shadow_d[i] = shadow_q[i-1];
        end
        busy = d_in_valid_q;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            busy = busy | shadow_q[i].valid;
        end
        busy_prev_d = busy;
    end

    always_comb begin
        tap_valid = '0;
        tap_id    = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            tap_valid[k]           = shadow_q[TAP_DEPTHS[k]-1].valid;
            tap_id[k*ID_W +: ID_W] = shadow_q[TAP_DEPTHS[k]-1].id;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            d_in_q       <= '0;
            d_in_valid_q <= 1'b0;
            issue_id_q   <= '0;
            busy_prev_q  <= 1'b0;
            for (int i = 0; i < MAX_DEPTH; i++) shadow_q[i] <= '0;
        end else begin
            d_in_q       <= d_in_d;
            d_in_valid_q <= d_in_valid_d;
            issue_id_q   <= issue_id_d;
            busy_prev_q  <= busy_prev_d;
            for (int i = 0; i < MAX_DEPTH; i++) shadow_q[i] <= shadow_d[i];
        end
    end

    assign d_in       = d_in_q;
    assign d_in_valid = d_in_valid_q;
    assign drained    = busy_prev_q && !busy;

endmodule
